// File: rtl/norm_pkg.sv
// Shared types and width helpers for the psum normaliser.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic MODE_L1  = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  localparam int BW_DEF   = 8;
  localparam int COL_DEF  = 8;
  localparam int FRAC_DEF = 8;

  // Never returns 0 so counters stay at least one bit wide.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int ch_width(input int col);
    return clog2_min1(col);
  endfunction

  function automatic int iter_width(input int frac);
    return clog2_min1(frac + 1);
  endfunction

  function automatic int denom_width(input int bw_psum, input int col);
    return bw_psum + $clog2(col);
  endfunction

endpackage

// File: rtl/norm_div_seq.sv
// Restoring divider: one quotient bit per cycle, frac+1 cycles per division.
// The first iteration works on num directly, so there is no load cycle.
module norm_div_seq
  import norm_pkg::*;
#(
  parameter int bw_psum = 20,
  parameter int dw      = 23,
  parameter int frac    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [bw_psum-1:0] num,
  input  logic [dw-1:0]      den,
  input  logic               neg,
  output logic [bw_psum-1:0] result,
  output logic               done
);

  localparam int qw = frac + 1;
  localparam int iw = iter_width(frac);
  localparam logic [iw-1:0] ITER_LAST = iw'(frac);

  logic          active;
  logic          run;
  logic          q_bit;
  logic [iw-1:0] iter;
  logic [iw-1:0] cur_iter;
  logic [dw:0]   rem;
  logic [dw:0]   r_cur;
  logic [dw:0]   r_sub;
  logic [qw-1:0] quo;
  logic [qw-1:0] quo_next;
  logic [bw_psum-1:0] mag;

  always_comb begin
    run      = start | active;
    cur_iter = start ? '0 : iter;
    r_cur    = start ? (dw+1)'(num) : rem;
    q_bit    = (r_cur >= {1'b0, den});
    r_sub    = q_bit ? (r_cur - {1'b0, den}) : r_cur;
    quo_next = qw'({quo, q_bit});
    done     = run && (cur_iter == ITER_LAST);
    mag      = bw_psum'(quo_next);
    result   = neg ? -mag : mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      iter   <= '0;
      rem    <= '0;
      quo    <= '0;
    end else if (run) begin
      rem    <= r_sub << 1;
      quo    <= quo_next;
      iter   <= done ? '0 : cur_iter + iw'(1);
      active <= !done;
    end
  end

endmodule

// File: rtl/norm_seq.sv
// Psum vector normaliser: per-vector L1 or max-abs denominator, one shared divider.
//   state | meaning
//   IDLE  | waiting for an input vector, in_ready high
//   SUM   | accumulating the denominator, one channel per cycle
//   DIV   | dividing each channel in turn, frac+1 cycles each
//   OUT   | result held until out_ready
module norm_seq
  import norm_pkg::*;
#(
  parameter int bw      = BW_DEF,
  parameter int bw_psum = 2*bw + 4,
  parameter int col     = COL_DEF,
  parameter int frac    = FRAC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw_psum*col-1:0] in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  output logic [bw_psum*col-1:0] out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int cw = ch_width(col);
  localparam int dw = denom_width(bw_psum, col);
  localparam logic [cw-1:0] CH_LAST = cw'(col - 1);

  if (frac > bw_psum - 2) begin : g_frac_chk
    $error("norm_seq: frac must not exceed bw_psum-2");
  end
  if (bw_psum < 2*bw) begin : g_bw_chk
    $error("norm_seq: bw_psum narrower than a full product");
  end

  state_t state, state_next;

  logic [bw_psum*col-1:0] vec_q;
  logic                   mode_q;
  logic [cw-1:0]          ch;
  logic [dw-1:0]          denom;
  logic [dw-1:0]          denom_next;
  logic [dw-1:0]          abs_ext;
  logic [bw_psum-1:0]     x_k;
  logic [bw_psum-1:0]     abs_k;
  logic                   launch;
  logic                   div_start;
  logic                   div_done;
  logic [bw_psum-1:0]     div_res;

  // |x| kept at bw_psum bits unsigned so the most negative psum is exact.
  always_comb begin
    x_k     = vec_q[ch*bw_psum +: bw_psum];
    abs_k   = x_k[bw_psum-1] ? (~x_k + bw_psum'(1)) : x_k;
    abs_ext = dw'(abs_k);
    denom_next = denom;
    case (mode_q)
      MODE_L1:  denom_next = denom + abs_ext;
      MODE_MAX: denom_next = (abs_ext > denom) ? abs_ext : denom;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = SUM;
      SUM:  if (ch == CH_LAST) state_next = (denom_next == '0) ? OUT : DIV;
      DIV:  if (div_done && ch == CH_LAST) state_next = OUT;
      OUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  assign div_start = (state == DIV) && launch;

  // ch wraps to 0 after the last channel because col is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_q  <= '0;
      mode_q <= MODE_L1;
      out    <= '0;
      ch     <= '0;
      denom  <= '0;
      launch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec_q  <= in;
            mode_q <= mode;
            out    <= '0;
            ch     <= '0;
            denom  <= '0;
          end
        end
        SUM: begin
          denom <= denom_next;
          ch    <= ch + cw'(1);
          if (ch == CH_LAST) launch <= (denom_next != '0);
        end
        DIV: begin
          launch <= 1'b0;
          if (div_done) begin
            out[ch*bw_psum +: bw_psum] <= div_res;
            ch     <= ch + cw'(1);
            launch <= (ch != CH_LAST);
          end
        end
        default: ;
      endcase
    end
  end

  norm_div_seq #(
    .bw_psum (bw_psum),
    .dw      (dw),
    .frac    (frac)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .start  (div_start),
    .num    (abs_k),
    .den    (denom),
    .neg    (x_k[bw_psum-1]),
    .result (div_res),
    .done   (div_done)
  );

endmodule

// File: tb/tb_norm_seq.sv
// Scoreboard bench for norm_seq: driver pushes model results, monitor pops on out_valid.
module tb_norm_seq;
  import norm_pkg::*;

  localparam int BW   = 8;
  localparam int BWP  = 2*BW + 4;
  localparam int COL  = 8;
  localparam int FRAC = 8;
  localparam int W    = BWP*COL;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_vec = '0;
  logic         in_valid = 1'b0;
  logic         mode = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic [W-1:0] out_vec;
  logic         out_valid;
  logic         busy;

  norm_seq #(.bw(BW), .bw_psum(BWP), .col(COL), .frac(FRAC)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out       (out_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;

  typedef struct {
    logic [W-1:0] vec;
    int           lat;
    int           acc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: denominators and quotients from plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] v, input logic m, output int lat);
    longint a [COL];
    longint d = 0;
    longint xs, q, rs;
    logic [BWP-1:0] e;
    logic [W-1:0] r = '0;
    for (int k = 0; k < COL; k++) begin
      e = v[k*BWP +: BWP];
      xs = longint'($signed(e));
      a[k] = (xs < 0) ? -xs : xs;
      if (m == MODE_MAX) d = (a[k] > d) ? a[k] : d;
      else d += a[k];
    end
    lat = (d == 0) ? COL : COL*(FRAC+2);
    if (d != 0) begin
      for (int k = 0; k < COL; k++) begin
        e = v[k*BWP +: BWP];
        xs = longint'($signed(e));
        q = (a[k] << FRAC) / d;
        rs = (xs < 0) ? -q : q;
        r[k*BWP +: BWP] = rs[BWP-1:0];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pack(input int e [COL]);
    logic [W-1:0] r = '0;
    for (int k = 0; k < COL; k++) r[k*BWP +: BWP] = BWP'(e[k]);
    return r;
  endfunction

  function automatic int rnd_elem();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return int'($urandom_range(0, 200)) - 100;
      2: return int'($urandom_range(0, 2**20 - 1)) - 2**19;
      default: return ($urandom_range(0, 1) != 0) ? -(2**19) : (2**19 - 1);
    endcase
  endfunction

  always @(negedge clk) if (!reset && in_valid && in_ready) n_acc++;

  logic         prev_valid = 1'b0;
  logic [W-1:0] held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%h required=none", out_vec);
        end else begin
          e = sb.pop_front();
          check("result", out_vec, e.vec);
          check("latency", W'(cyc - e.acc), W'(e.lat));
        end
        held = out_vec;
      end else if (out_valid) begin
        check("hold_out", out_vec, held);
        check("hold_in_ready", W'(in_ready), W'(1'b0));
      end
      prev_valid = out_valid;
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [W-1:0] v, input logic m, input bit drop);
    exp_t e;
    int lat;
    int n = 0;
    bit got = 1'b0;
    in_vec = v;
    mode = m;
    in_valid = 1'b1;
    while (!got && n < 400) begin
      @(negedge clk);
      if (in_ready && !reset) begin
        e.vec = model(v, m, lat);
        e.lat = lat;
        e.acc = cyc + 1;
        sb.push_back(e);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 2000) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=pending=%0d required=0", sb.size());
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vals [COL];
    int n;
    int acc0;
    logic [W-1:0] v;
    logic [W-1:0] exp_v;
    int lat;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", out_vec, '0);
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    check("rst_busy", W'(busy), W'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    vals = '{100, -100, 0, 0, 0, 0, 0, 0};
    send(pack(vals), MODE_L1, 1'b1);
    wait_idle(1'b0);
    vals = '{128, -128, 0, 0, 0, 0, 0, 0};
    check("l1_basic", out_vec, pack(vals));

    vals = '{100, -100, 50, 0, 0, 0, 0, 0};
    send(pack(vals), MODE_MAX, 1'b1);
    wait_idle(1'b0);
    vals = '{256, -256, 128, 0, 0, 0, 0, 0};
    check("max_basic", out_vec, pack(vals));

    vals = '{1, 1, -1, 0, 0, 0, 0, 0};
    send(pack(vals), MODE_L1, 1'b1);
    wait_idle(1'b0);
    vals = '{85, 85, -85, 0, 0, 0, 0, 0};
    check("l1_trunc", out_vec, pack(vals));

    send('0, MODE_L1, 1'b1);
    wait_idle(1'b0);
    check("zero_l1", out_vec, '0);
    send('0, MODE_MAX, 1'b1);
    wait_idle(1'b0);
    check("zero_max", out_vec, '0);

    vals = '{-(2**19), 0, 0, 0, 0, 0, 0, 0};
    send(pack(vals), MODE_L1, 1'b1);
    wait_idle(1'b0);
    vals = '{-256, 0, 0, 0, 0, 0, 0, 0};
    check("most_negative", out_vec, pack(vals));

    // Backpressure with an ignored input pulse during OUT.
    vals = '{300, -20, 7, 0, -1000, 5, 0, 44};
    v = pack(vals);
    exp_v = model(v, MODE_MAX, lat);
    out_ready = 1'b0;
    send(v, MODE_MAX, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_reached_out", W'(out_valid), W'(1'b1));
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_vec = ~v;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_no_accept", W'(n_acc - acc0), W'(0));
    @(negedge clk);
    check("bp_valid_held", W'(out_valid), W'(1'b1));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", W'(in_ready), W'(1'b1));
    check("bp_valid_dropped", W'(out_valid), W'(1'b0));
    check("bp_out_kept", out_vec, exp_v);
    @(posedge clk);
    #1;

    // Reset in the middle of DIV after some channels are written.
    vals = '{9, -3, 27, 1, 0, -5, 2, 8};
    send(pack(vals), MODE_L1, 1'b1);
    repeat (37) @(posedge clk);
    #1;
    check("mid_busy", W'(busy), W'(1'b1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out", out_vec, '0);
    check("mid_rst_valid", W'(out_valid), W'(1'b0));
    check("mid_rst_in_ready", W'(in_ready), W'(1'b1));
    check("mid_rst_busy", W'(busy), W'(1'b0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    vals = '{-77, 12, 0, 400, 3, -3, 90, 1};
    send(pack(vals), MODE_MAX, 1'b1);
    wait_idle(1'b0);

    // Back-to-back with in_valid held high.
    acc0 = n_acc;
    vals = '{10, 20, 30, 40, -50, 60, 70, 80};
    send(pack(vals), MODE_L1, 1'b0);
    vals = '{-1, 2, -3, 4, -5, 6, -7, 8};
    send(pack(vals), MODE_MAX, 1'b0);
    vals = '{5000, 0, 0, -5000, 0, 2500, 0, 0};
    send(pack(vals), MODE_L1, 1'b1);
    wait_idle(1'b0);
    check("b2b_accepts", W'(n_acc - acc0), W'(3));

    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < COL; k++) vals[k] = rnd_elem();
      send(pack(vals), 1'($urandom_range(0, 1)), 1'b1);
      wait_idle(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/norm_seq.md
Name: norm_seq

Overview:
- Parametrised successor to the psum normaliser. Takes a vector of `col` signed partial sums and outputs each element divided by a per-vector denominator, as a signed fixed-point fraction with `frac` fractional bits.
- Two denominator modes: L1 (sum of |x|) and max-abs (max |x|).
- One shared sequential restoring divider serves all channels.
- Full valid/ready handshake on both the input and output sides. Sits between the psum accumulation stage and the output SRAM write path.

Parameters:
- bw, 8, operand bit width of the MAC array.
- bw_psum, 2*bw+4, width of one signed psum element.
- col, 8, channel count; power of two, 2..64.
- frac, 8, fractional bits of the result; must satisfy frac <= bw_psum-2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in  in  bw_psum*col  psum vector; channel k is in[bw_psum*(k+1)-1 : bw_psum*k], signed.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- mode  in  1  0 = L1 normalisation, 1 = max-abs normalisation; sampled with `in`.
- out  out  bw_psum*col  normalised vector, same channel packing as `in`, signed.
- out_valid  out  1  `out` holds a complete result.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: state IDLE; out=0; out_valid=0; in_ready=1; busy=0. Reset at any cycle aborts the operation in progress and discards it; no partial result is ever flagged valid.
- States: IDLE -> SUM -> DIV -> OUT -> IDLE.
- in_ready = (state==IDLE). out_valid = (state==OUT).
- Accept:
  - An input is accepted on the edge where in_valid && in_ready.
  - That edge latches `in` and `mode` into an internal buffer, clears `out` to 0 and enters SUM.
  - Inputs are ignored in every other state.
- Abs width: |x| is computed at bw_psum bits unsigned, so the most negative value -2^(bw_psum-1) is exact.
- Denominator width: dw = bw_psum + clog2(col) bits unsigned.
- SUM:
  - Lasts exactly col cycles, processing channel 0..col-1 one per cycle.
  - mode 0: denom += |x_k|. mode 1: denom = max(denom, |x_k|).
- SUM exit:
  - If denom==0, go to OUT directly; all outputs remain 0.
  - Otherwise go to DIV.
- DIV:
  - Channels are processed in order 0..col-1, each taking exactly frac+1 cycles.
  - Restoring division: the remainder R starts at |x_k|. In each of the frac+1 iterations, from the MSB of the quotient downward: the quotient bit is (R>=denom); if the bit is 1, R -= denom; then R <<= 1. R is dw+1 bits wide.
  - The quotient q = floor(|x_k|*2^frac/denom) satisfies q <= 2^frac.
  - The result is sign-applied (negated if x_k<0, i.e. truncation toward zero) and written to out channel k on the channel's last cycle.
- DIV length: col*(frac+1) cycles, after which the block enters OUT.
- Latency, measured from the accept edge to the edge where out_valid rises:
  - nonzero denom: col*(frac+2) cycles (80 at defaults).
  - zero denom: col cycles (8 at defaults).
- OUT:
  - out and out_valid are held stable until out_ready=1.
  - The edge with out_valid && out_ready returns to IDLE and drops out_valid; `out` keeps its value until the next accept.
  - out_ready is a don't-care outside OUT.
- Throughput: no overlap. The next vector is accepted no earlier than the cycle after the OUT handshake.
- Result range: the magnitude of each output is <= 2^frac. In L1 mode the output magnitudes sum to <= 2^frac. In max-abs mode the largest element maps to exactly ±2^frac.

Decomposition:
- Package norm_pkg holds:
  - the state enum (IDLE, SUM, DIV, OUT);
  - the mode encodings (MODE_L1=0, MODE_MAX=1);
  - derived width constants: abs width bw_psum; dw = bw_psum+clog2(col); counter widths clog2(col) and clog2(frac+1).
- Sub-module norm_div_seq: a restoring divider with start/done signals.
  - Inputs: numerator magnitude, denom, sign.
  - Output: signed bw_psum result; done pulses after exactly frac+1 cycles.
  - The top level holds the FSM, channel counter, abs/accumulate logic and the output register.

Test Plan:
- L1 basic: mode=0, in={100,-100,0,0,0,0,0,0} -> out={128,-128,0,...}; out_valid rises exactly 80 cycles after the accept edge.
- Max-abs and truncation: mode=1, in={100,-100,50,0,...} -> out={256,-256,128,0,...}. Then mode=0, in={1,1,-1,0,...} -> {85,85,-85,0,...} (truncation toward zero).
- Edge values: in all zeros (either mode) -> out all 0; out_valid rises 8 cycles after accept. Then in={-2^19,0,...}, mode 0 -> channel 0 = -256 and all others 0 (no abs overflow).
- Backpressure: hold out_ready=0 for 10 cycles during OUT -> out and out_valid stable, in_ready=0. A new in_valid pulse in that window is not accepted. After out_ready=1 for one edge: in_ready=1 on the following cycle.
- Reset mid-operation: assert reset at cycle 30 of DIV -> next cycle out=0, out_valid=0, in_ready=1, busy=0. A fresh vector afterwards produces the correct result with the nominal latency.
- Back-to-back: in_valid held high with 3 distinct vectors and out_ready=1 -> 3 results in order, each 80 cycles after its own accept; exactly one accept per vector.
